// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to index n items; never less than one so a counter always exists.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned v = 1; v < n; v = v * 2) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle between a client and the chunked sequential adder.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/rca_chunk.sv
// Combinational N-bit ripple of full-adder cells; exposes the carry into the top bit for overflow.
module rca_chunk #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] c;

    // Ripple the carry through N full-adder cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout  = c[N];
        c_msb = c[N-1];
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through one reused ripple chunk,
// with start/busy/done handshake, carry-out and signed-overflow flags.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    seq_chunk_adder_if.slave  bus
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = clog2_min1(NCHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    generate
        if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t                        state;
    logic [IDXW-1:0]               idx;
    logic                          carry;
    logic [NCHUNK-1:0][CHUNK-1:0]  a_reg;
    logic [NCHUNK-1:0][CHUNK-1:0]  b_reg;
    logic [NCHUNK-1:0][CHUNK-1:0]  work;
    logic [NCHUNK-1:0][CHUNK-1:0]  work_next;
    logic [CHUNK-1:0]              ch_a;
    logic [CHUNK-1:0]              ch_b;
    logic [CHUNK-1:0]              ch_s;
    logic                          ch_cout;
    logic                          ch_cmsb;
    logic                          busy_r;
    logic                          done_r;
    logic [WIDTH-1:0]              sum_r;
    logic                          cout_r;
    logic                          ovf_r;

    // Select the current chunk and merge its sum into the working result.
    always_comb begin
        ch_a           = a_reg[idx];
        ch_b           = b_reg[idx];
        work_next      = work;
        work_next[idx] = ch_s;
    end

    rca_chunk #(.N(CHUNK)) u_rca (
        .a     (ch_a),
        .b     (ch_b),
        .cin   (carry),
        .s     (ch_s),
        .cout  (ch_cout),
        .c_msb (ch_cmsb)
    );

    // Control FSM with operand, working and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            work   <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_reg  <= bus.a;
                        b_reg  <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub ? 1'b1 : bus.cin;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= ST_RUN;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work  <= work_next;
                    carry <= ch_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        // Last chunk: publish the merged result directly, not the stale working copy.
                        sum_r  <= work_next;
                        cout_r <= ch_cout;
                        ovf_r  <= ch_cmsb ^ ch_cout;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        idx    <= '0;
                        state  <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed scoreboard bench for seq_chunk_adder in CHUNK=4, CHUNK=16 and CHUNK=1 builds.
module tb_seq_chunk_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(16)) if4  ();
    seq_chunk_adder_if #(.WIDTH(16)) if16 ();
    seq_chunk_adder_if #(.WIDTH(16)) if1  ();

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    seq_chunk_adder #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   ncomp = 0;
    int   nfail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // sel: 0 = CHUNK 4, 1 = CHUNK 16, 2 = CHUNK 1
    function automatic int nch(input int sel);
        case (sel)
            0:       return 4;
            1:       return 1;
            default: return 16;
        endcase
    endfunction

    function automatic logic get_done(input int sel);
        case (sel)
            0:       return if4.done;
            1:       return if16.done;
            default: return if1.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0:       return if4.busy;
            1:       return if16.busy;
            default: return if1.busy;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int sel);
        case (sel)
            0:       return if4.sum;
            1:       return if16.sum;
            default: return if1.sum;
        endcase
    endfunction

    function automatic logic get_cout(input int sel);
        case (sel)
            0:       return if4.cout;
            1:       return if16.cout;
            default: return if1.cout;
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0:       return if4.ovf;
            1:       return if16.ovf;
            default: return if1.ovf;
        endcase
    endfunction

    task automatic set_ops(input logic [15:0] a_i, input logic [15:0] b_i,
                           input logic sub_i, input logic cin_i);
        if4.a  = a_i;  if4.b  = b_i;  if4.sub  = sub_i; if4.cin  = cin_i;
        if16.a = a_i;  if16.b = b_i;  if16.sub = sub_i; if16.cin = cin_i;
        if1.a  = a_i;  if1.b  = b_i;  if1.sub  = sub_i; if1.cin  = cin_i;
    endtask

    task automatic set_start(input int sel, input logic v);
        case (sel)
            0:       if4.start  = v;
            1:       if16.start = v;
            default: if1.start  = v;
        endcase
    endtask

    // Drive a request and, if asked, push the reference result.
    task automatic issue(input int sel, input logic [15:0] a_i, input logic [15:0] b_i,
                         input logic sub_i, input logic cin_i, input bit push);
        exp_t        e;
        logic [15:0] be;
        logic        c0;
        logic [16:0] full;
        be     = sub_i ? ~b_i : b_i;
        c0     = sub_i ? 1'b1 : cin_i;
        full   = {1'b0, a_i} + {1'b0, be} + {16'd0, c0};
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a_i[15] == be[15]) && (full[15] != a_i[15]);
        e.lat  = nch(sel) + 1;
        e.busy = nch(sel);
        set_ops(a_i, b_i, sub_i, cin_i);
        set_start(sel, 1'b1);
        if (push) sb.push_back(e);
    endtask

    // Wait (bounded) for done, then pop and compare. poke re-pulses start in the 2nd RUN cycle.
    task automatic complete(input int sel, input string tag, input bit poke);
        int   lat;
        int   bcnt;
        exp_t e;
        lat  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) set_start(sel, 1'b0);
            if (poke && lat == 2) begin
                set_ops(16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
                set_start(sel, 1'b1);
            end
            if (poke && lat == 3) set_start(sel, 1'b0);
            if (get_busy(sel)) bcnt++;
        end while (!get_done(sel) && lat < 40);
        check({tag, "_done_seen"}, 32'(get_done(sel)), 32'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_entry"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            if (get_done(sel)) begin
                check({tag, "_sum"},  32'(get_sum(sel)),  32'(e.sum));
                check({tag, "_cout"}, 32'(get_cout(sel)), 32'(e.cout));
                check({tag, "_ovf"},  32'(get_ovf(sel)),  32'(e.ovf));
                check({tag, "_lat"},  32'(lat),           32'(e.lat));
                check({tag, "_busy"}, 32'(bcnt),          32'(e.busy));
            end
        end
    endtask

    initial begin
        int seen;
        set_ops('0, '0, 1'b0, 1'b0);
        if4.start  = 1'b0;
        if16.start = 1'b0;
        if1.start  = 1'b0;
        rst        = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_busy",   32'(if4.busy),  32'd0);
        check("rst_done",   32'(if4.done),  32'd0);
        check("rst_sum",    32'(if4.sum),   32'd0);
        check("rst_cout",   32'(if4.cout),  32'd0);
        check("rst_ovf",    32'(if4.ovf),   32'd0);
        check("rst_sum16",  32'(if16.sum),  32'd0);
        check("rst_busy1",  32'(if1.busy),  32'd0);
        rst = 1'b0;

        issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        complete(0, "ripple", 1'b0);
        @(negedge clk);
        check("done_pulse_width", 32'(if4.done), 32'd0);
        check("sum_held",         32'(if4.sum),  32'h0000);
        check("cout_held",        32'(if4.cout), 32'd1);

        issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        complete(0, "sovf", 1'b0);

        issue(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        complete(0, "sub_borrow", 1'b0);

        issue(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1);
        complete(0, "sub_noborrow", 1'b0);

        issue(0, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        complete(0, "start_ignored", 1'b1);

        issue(0, 16'h00FF, 16'h0101, 1'b0, 1'b1, 1'b1);
        complete(0, "chain_first", 1'b0);
        issue(0, 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b1);
        complete(0, "chain_second", 1'b0);

        issue(0, 16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        set_start(0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy",  32'(if4.busy),      32'd0);
        check("abort_done",  32'(if4.done),      32'd0);
        check("abort_sum",   32'(if4.sum),       32'd0);
        check("abort_cout",  32'(if4.cout),      32'd0);
        check("abort_ovf",   32'(if4.ovf),       32'd0);
        check("abort_state", 32'(u_dut4.state),  32'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if4.done) seen++;
        end
        check("abort_no_done", 32'(seen), 32'd0);

        issue(1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        complete(1, "chunk16", 1'b0);

        issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        complete(2, "chunk1", 1'b0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle parametrised ripple-carry adder/subtractor that processes CHUNK bits per clock through a full-adder chain.
- Successor to the single-bit behavioural full adder: generalises width, adds a subtract mode and overflow detection, and adds a start/busy/done handshake.
- Used wherever a wide add can trade latency for area in the datapath labs.

Parameters:
- WIDTH, 16, operand/result width in bits.
- CHUNK, 4, bits added per clock. WIDTH % CHUNK must be 0; any other value is an elaboration error.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when not busy.
- sub  input  1  0 = a+b+cin; 1 = a-b (cin ignored).
- a  input  WIDTH  operand A; latched on accepted start.
- b  input  WIDTH  operand B; latched on accepted start.
- cin  input  1  carry-in for add mode.
- busy  output  1  high while chunks are being computed.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result, held until the next completion.
- cout  output  1  carry-out of the MSB. In sub mode, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock, synchronous, active-high. On rst=1 at a rising edge:
  - state=IDLE;
  - busy, done, sum, cout, ovf, chunk index and internal carry all go to 0.
  - rst overrides start in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE, start=1: latch a, b_eff = sub ? ~b : b, and carry = sub ? 1 : cin. Set idx=0 and go to RUN. start=0: stay in IDLE.
- RUN, busy=1:
  - Each cycle: add chunk idx of a and b_eff plus carry through the CHUNK-bit ripple.
  - Write the CHUNK sum bits into the working result at [idx*CHUNK +: CHUNK].
  - carry <= chunk carry-out; idx <= idx+1.
  - When idx = NCHUNK-1: capture the carry into the MSB for ovf, then go to DONE.
  - start is ignored throughout RUN.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - sum/cout/ovf registers update on the RUN->DONE edge, so they are valid while done=1, and are held afterwards.
  - start=1 in DONE is accepted (latch and go to RUN); otherwise go to IDLE.
- Latency:
  - start accepted at edge T; done=1 during the cycle after edge T+NCHUNK.
  - Start-to-done is NCHUNK+1 clocks.
  - Back-to-back throughput is one result per NCHUNK+1 clocks.
- Result registers are not touched during RUN; the working register is separate.
- Widths:
  - idx is clog2(NCHUNK) bits, minimum 1.
  - All arithmetic is modulo 2^WIDTH.
  - ovf uses the two's-complement interpretation in both modes.
- Boundaries:
  - CHUNK=WIDTH gives a single RUN cycle (latency 2).
  - CHUNK=1 is a bit-serial adder.
  - Operand changes after start do not affect the result.
  - Reset mid-RUN aborts the operation: no done pulse, and sum is cleared.

Decomposition:
- Package seq_adder_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and the clog2 helper function.
- Sub-module rca_chunk (parameter N):
  - Combinational ripple of N full-adder cells.
  - Ports: a[N], b[N], cin → s[N], cout, c_msb (carry into bit N-1).
  - Instantiated once and reused every RUN cycle.
- Control FSM, operand registers and result registers live in seq_chunk_adder.

Test Plan:
- Carry ripple across chunks (WIDTH=16, CHUNK=4): a=0xFFFF, b=0x0001, cin=0, sub=0 → done 5 clocks after the start edge; sum=0x0000, cout=1, ovf=0; busy high for exactly 4 cycles.
- Signed overflow: a=0x7FFF, b=0x0001 → sum=0x8000, cout=0, ovf=1.
- Subtract with borrow: a=0x0005, b=0x0007, sub=1, cin=1 (must be ignored) → sum=0xFFFE, cout=0, ovf=0.
- Subtract without borrow: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Handshake:
  - Pulse start again in the 2nd RUN cycle with different operands → ignored; the first result is unchanged.
  - start asserted during the DONE cycle → a new operation begins immediately, with a second done pulse 5 clocks later.
- Reset and degenerate configs:
  - rst=1 in the 3rd RUN cycle → next cycle state IDLE, sum=0, cout=0, ovf=0, and no done pulse.
  - Repeat the 0xFFFF+1 case with CHUNK=16 (done after 2 clocks) and with CHUNK=1 (done after 17 clocks).
